// File: rtl/imem_loader_if.sv
// Byte-stream and IMEM write-port bundle for imem_loader.
// The master side is the host byte source and observer; the slave side is the loader.
interface imem_loader_if #(
  parameter int ADDR_W = 13
);
  logic              i_start;
  logic              i_byte_valid;
  logic [7:0]        i_byte_data;
  logic              o_byte_ready;
  logic              o_we;
  logic [ADDR_W-1:0] o_waddr;
  logic [31:0]       o_wdata;
  logic              o_busy;
  logic              o_done;
  logic              o_err;
  logic              o_cpu_hold;

  modport master (
    output i_start, i_byte_valid, i_byte_data,
    input  o_byte_ready, o_we, o_waddr, o_wdata, o_busy, o_done, o_err, o_cpu_hold
  );

  modport slave (
    input  i_start, i_byte_valid, i_byte_data,
    output o_byte_ready, o_we, o_waddr, o_wdata, o_busy, o_done, o_err, o_cpu_hold
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: length-prefixed LE byte stream -> one-cycle IMEM word writes.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the data.
//
// state   | meaning
// IDLE    | out of reset, waiting for i_start
// LEN_LO  | expecting low byte of word count
// LEN_HI  | expecting high byte of word count, range-checked here
// DATA    | assembling words, writing each one cycle after its 4th byte
// CHK     | expecting checksum byte (checksum build only)
// DONE    | image loaded, core released
// ERR     | bad length or checksum, core held
module imem_loader #(
  parameter int ADDR_W        = 13,
  parameter int DEPTH_WORDS   = 2048,
  parameter int HOLD_ON_RESET = 1
) (
  input logic          i_clk,
  input logic          i_reset,
  imem_loader_if.slave bus
);

  localparam int              IDX_W    = ADDR_W - 2;
  localparam logic            HOLD_RST = (HOLD_ON_RESET != 0);
  localparam logic [15:0]     DEPTH_N  = 16'(DEPTH_WORDS);
  localparam logic [IDX_W-1:0] IDX_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t           state;
  logic [7:0]       len_lo;
  logic [15:0]      words_left;
  logic [IDX_W-1:0] word_idx;
  logic [1:0]       byte_cnt;
  logic [23:0]      word_buf;
  logic             hs;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       chk_acc;
`endif

  assign hs = bus.i_byte_valid & bus.o_byte_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state            <= S_IDLE;
      len_lo           <= '0;
      words_left       <= '0;
      word_idx         <= '0;
      byte_cnt         <= '0;
      word_buf         <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_acc          <= '0;
`endif
      bus.o_byte_ready <= 1'b0;
      bus.o_we         <= 1'b0;
      bus.o_waddr      <= '0;
      bus.o_wdata      <= '0;
      bus.o_busy       <= 1'b0;
      bus.o_done       <= 1'b0;
      bus.o_err        <= 1'b0;
      bus.o_cpu_hold   <= HOLD_RST;
    end else begin
      bus.o_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (bus.i_start) begin
            state            <= S_LEN_LO;
            word_idx         <= '0;
            byte_cnt         <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_acc          <= '0;
`endif
            bus.o_byte_ready <= 1'b1;
            bus.o_busy       <= 1'b1;
            bus.o_done       <= 1'b0;
            bus.o_err        <= 1'b0;
            bus.o_cpu_hold   <= 1'b1;
          end
        end
        S_LEN_LO: begin
          if (hs) begin
            len_lo <= bus.i_byte_data;
            state  <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (hs) begin
            words_left <= {bus.i_byte_data, len_lo};
            if ({bus.i_byte_data, len_lo} > DEPTH_N) begin
              state            <= S_ERR;
              bus.o_byte_ready <= 1'b0;
              bus.o_busy       <= 1'b0;
              bus.o_err        <= 1'b1;
              bus.o_cpu_hold   <= 1'b1;
            end else if ({bus.i_byte_data, len_lo} == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state <= S_CHK;
`else
              state            <= S_DONE;
              bus.o_byte_ready <= 1'b0;
              bus.o_busy       <= 1'b0;
              bus.o_done       <= 1'b1;
              bus.o_cpu_hold   <= 1'b0;
`endif
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (hs) begin
            byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_acc  <= chk_acc ^ bus.i_byte_data;
`endif
            if (byte_cnt == 2'd3) begin
              bus.o_we    <= 1'b1;
              bus.o_waddr <= {word_idx, 2'b00};
              bus.o_wdata <= {bus.i_byte_data, word_buf};
              word_idx    <= word_idx + IDX_ONE;
              words_left  <= words_left - 16'd1;
              // words_left is a down-counter; terminal count marks the image's last word
              if (words_left == 16'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state <= S_CHK;
`else
                state            <= S_DONE;
                bus.o_byte_ready <= 1'b0;
                bus.o_busy       <= 1'b0;
                bus.o_done       <= 1'b1;
                bus.o_cpu_hold   <= 1'b0;
`endif
              end
            end else begin
              word_buf[8*byte_cnt +: 8] <= bus.i_byte_data;
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (hs) begin
            bus.o_byte_ready <= 1'b0;
            bus.o_busy       <= 1'b0;
            if (bus.i_byte_data == chk_acc) begin
              state          <= S_DONE;
              bus.o_done     <= 1'b1;
              bus.o_cpu_hold <= 1'b0;
            end else begin
              state          <= S_ERR;
              bus.o_err      <= 1'b1;
              bus.o_cpu_hold <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state            <= S_IDLE;
          bus.o_byte_ready <= 1'b0;
          bus.o_busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued at each 4th-byte handshake,
// a negedge monitor pops and compares every o_we pulse.
module tb_imem_loader;

  localparam int ADDR_W = 13;
  localparam int DEPTH  = 2048;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    int                cyc;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(
    .ADDR_W(ADDR_W),
    .DEPTH_WORDS(DEPTH),
    .HOLD_ON_RESET(1)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .bus(bus)
  );

  wr_t               expq[$];
  wr_t               mon_e;
  int                checks = 0;
  int                errors = 0;
  int                cyc = 0;
  int                writes_seen = 0;
  logic [ADDR_W-1:0] last_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.o_we === 1'b1) begin
      writes_seen++;
      last_addr = bus.o_waddr;
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write", bus.o_waddr, bus.o_wdata);
      end else begin
        mon_e = expq.pop_front();
        check("waddr", 32'(bus.o_waddr), 32'(mon_e.addr));
        check("wdata", bus.o_wdata, mon_e.data);
        check("we_latency_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // One byte transfer; hs_cyc is the negedge cycle before the accepting edge.
  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit start_too,
                           output bit ok, output int hs_cyc);
    int waited;
    waited = 0;
    ok = 1'b0;
    hs_cyc = 0;
    if (gaps && $urandom_range(0, 2) == 0) begin
      bus.i_byte_valid = 1'b0;
      bus.i_byte_data  = 8'($urandom);
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    bus.i_byte_valid = 1'b1;
    bus.i_byte_data  = b;
    bus.i_start      = start_too;
    while (!ok && waited < 200) begin
      @(negedge clk);
      if (bus.o_byte_ready === 1'b1) begin
        ok = 1'b1;
        hs_cyc = cyc;
      end
      @(posedge clk);
      #1;
      waited++;
    end
    bus.i_byte_valid = 1'b0;
    bus.i_start      = 1'b0;
    if (!ok) check("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_start();
    bus.i_start = 1'b1;
    @(negedge clk);
    check("ready_before_start", 32'(bus.o_byte_ready), 32'd0);
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    @(negedge clk);
    check("busy_after_start", 32'(bus.o_busy), 32'd1);
    check("done_cleared", 32'(bus.o_done), 32'd0);
    check("err_cleared", 32'(bus.o_err), 32'd0);
    check("hold_after_start", 32'(bus.o_cpu_hold), 32'd1);
    check("ready_after_start", 32'(bus.o_byte_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_final(input bit exp_done);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("final_done", 32'(bus.o_done), 32'(exp_done));
    check("final_err", 32'(bus.o_err), 32'(!exp_done));
    check("final_busy", 32'(bus.o_busy), 32'd0);
    check("final_ready", 32'(bus.o_byte_ready), 32'd0);
    check("final_hold", 32'(bus.o_cpu_hold), 32'(!exp_done));
    check("pending_writes", 32'(expq.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Sends length, data (and checksum when built in); expectations come from word list.
  task automatic run_stream(input int n, input logic [31:0] words[$], input bit gaps,
                            input logic [7:0] chk_delta);
    bit         ok;
    int         hs;
    logic [15:0] nn;
    logic [7:0] x;
    logic [7:0] b;
    bit         exp_done;
    nn = 16'(n);
    x  = 8'h00;
    send_byte(nn[7:0], gaps, 1'b0, ok, hs);
    if (!ok) return;
    send_byte(nn[15:8], gaps, 1'b0, ok, hs);
    if (!ok) return;
    if (n > DEPTH) begin
      check_final(1'b0);
      return;
    end
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        b = words[i][8*k +: 8];
        x ^= b;
        send_byte(b, gaps, gaps && ($urandom_range(0, 7) == 0) && !(i == n - 1 && k == 3), ok, hs);
        if (!ok) return;
        if (k == 3) expq.push_back('{addr: ADDR_W'(i * 4), data: words[i], cyc: hs + 1});
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(x ^ chk_delta, gaps, 1'b0, ok, hs);
    if (!ok) return;
    exp_done = (chk_delta == 8'h00);
`else
    exp_done = 1'b1;
`endif
    check_final(exp_done);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w[$];
    bit          ok;
    int          hs;
    int          n;
    int          base;
    logic [7:0]  delta;

    bus.i_start      = 1'b0;
    bus.i_byte_valid = 1'b0;
    bus.i_byte_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(bus.o_byte_ready), 32'd0);
    check("rst_we", 32'(bus.o_we), 32'd0);
    check("rst_waddr", 32'(bus.o_waddr), 32'd0);
    check("rst_wdata", bus.o_wdata, 32'd0);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    check("rst_done", 32'(bus.o_done), 32'd0);
    check("rst_err", 32'(bus.o_err), 32'd0);
    check("rst_hold", 32'(bus.o_cpu_hold), 32'd1);

    // Byte offered in IDLE without start is never taken.
    @(posedge clk);
    #1;
    bus.i_byte_valid = 1'b1;
    bus.i_byte_data  = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_ready_low", 32'(bus.o_byte_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.i_byte_valid = 1'b0;

    // Reference two-word program.
    pulse_start();
    w = '{32'h00A00513, 32'h00500593};
    run_stream(2, w, 1'b0, 8'h00);

    // Length one past capacity.
    pulse_start();
    w = '{};
    run_stream(DEPTH + 1, w, 1'b0, 8'h00);

    // Empty image.
    pulse_start();
    run_stream(0, w, 1'b1, 8'h00);

`ifdef IMEM_LOADER_CHECKSUM_EN
    pulse_start();
    w = '{32'h44332211};
    run_stream(1, w, 1'b0, 8'h00);
    pulse_start();
    run_stream(1, w, 1'b0, 8'h01);
`endif

    // Randomized images with valid gaps and ignored mid-stream i_start.
    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(1, 6);
      w = '{};
      for (int i = 0; i < n; i++) w.push_back($urandom);
      delta = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      pulse_start();
      run_stream(n, w, 1'b1, delta);
    end

    // Reset after six data bytes: one word written, then silence.
    pulse_start();
    base = writes_seen;
    w = '{$urandom, $urandom, $urandom};
    send_byte(8'd3, 1'b1, 1'b0, ok, hs);
    send_byte(8'd0, 1'b1, 1'b0, ok, hs);
    for (int j = 0; j < 6; j++) begin
      send_byte(w[j / 4][8*(j % 4) +: 8], 1'b1, 1'b0, ok, hs);
      if (j == 3) expq.push_back('{addr: ADDR_W'(0), data: w[0], cyc: hs + 1});
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(bus.o_busy), 32'd0);
    check("abort_ready", 32'(bus.o_byte_ready), 32'd0);
    check("abort_hold", 32'(bus.o_cpu_hold), 32'd1);
    check("abort_done", 32'(bus.o_done), 32'd0);
    @(posedge clk);
    #1;
    bus.i_byte_valid = 1'b1;
    bus.i_byte_data  = 8'h5A;
    repeat (10) @(posedge clk);
    #1;
    bus.i_byte_valid = 1'b0;
    @(negedge clk);
    check("abort_write_count", 32'(writes_seen - base), 32'd1);
    check("abort_pending", 32'(expq.size()), 32'd0);
    @(posedge clk);
    #1;

    // Full-capacity image at full byte rate.
    w = '{};
    for (int i = 0; i < DEPTH; i++) w.push_back($urandom);
    pulse_start();
    base = writes_seen;
    run_stream(DEPTH, w, 1'b0, 8'h00);
    check("full_write_count", 32'(writes_seen - base), 32'(DEPTH));
    check("full_last_addr", 32'(last_addr), 32'h1FFC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
